ex_muldiv_unit: RTL

- Iterative multiply/divide unit in the EX stage, directly upstream of the EX/MEM pipeline register.
- Executes MULT/MULTU/DIV/DIVU over 32 iterations and owns the architectural HI/LO registers.
- Handles MTHI/MTLO writes.
- Drives busy to the hazard unit, which stalls IF/ID/ID-EX and holds the EX/MEM write enable low while busy.
- HI/LO feed the EX-stage hilo mux that produces the EX/MEM hilo input.

---
 rtl/ex_muldiv_unit_if.sv | 27 ++
 rtl/ex_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - operand/command and HI/LO result bundle for the EX-stage mul/div unit
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata, flush,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata, flush,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    ex_muldiv_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   lsr_q, lsr_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // 0x80000000 negates to itself, which is exactly the unsigned magnitude 2^31
    assign a_mag = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: acc holds the running high half, lsr shifts the multiplier out / product low half in
    assign mul_sum   = {1'b0, acc_q} + (lsr_q[0] ? {1'b0, opd_q} : '0);

    // Divide: acc is the partial remainder, lsr shifts the dividend out / quotient in
    assign div_shift = {acc_q, lsr_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opd_q;

    assign prod      = {acc_q, lsr_q};
    assign prod_neg  = -prod;
    assign quo_fix   = neg_lo_q ? -lsr_q : lsr_q;
    assign rem_fix   = neg_hi_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lsr_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lsr_q    <= lsr_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lsr_d    = lsr_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.flush) begin
                    if (bus.start) begin
                        state_d  = S_CALC;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        acc_d    = '0;
                        is_div_d = bus.op[1];
                        neg_lo_d = bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        if (bus.op[1]) begin
                            lsr_d    = a_mag;
                            opd_d    = b_mag;
                            neg_hi_d = bus.op[0] & bus.a[WIDTH-1];
                            dz_d     = (bus.b == '0);
                        end else begin
                            lsr_d    = b_mag;
                            opd_d    = a_mag;
                            neg_hi_d = 1'b0;
                            dz_d     = 1'b0;
                        end
                    end else begin
                        if (bus.mthi) hi_d = bus.wdata;
                        if (bus.mtlo) lo_d = bus.wdata;
                    end
                end
            end

            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (dz_q) begin
                    state_d = S_FIX;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        lsr_d = {lsr_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        lsr_d = {mul_sum[0], lsr_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    // A zero divisor completes the handshake but leaves HI/LO untouched
                    if (!dz_q) begin
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end else if (neg_lo_q) begin
                            hi_d = prod_neg[2*WIDTH-1:WIDTH];
                            lo_d = prod_neg[WIDTH-1:0];
                        end else begin
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
